// File: rtl/voice_scheduler_pkg.sv
// rtl/voice_scheduler_pkg.sv - shared types, widths and note table for the voice scheduler
//
// Purpose: holds the FSM state encoding, voice count, note-code field widths,
// period width and the octave-0 half-period table used by freq_gen.
// Ports: none (package).

package voice_scheduler_pkg;

  localparam int NUM_VOICES    = 4;
  localparam int VOICE_W       = 2;
  localparam int OCT_W         = 3;
  localparam int NOTE_W        = 4;
  localparam int CODE_W        = OCT_W + NOTE_W;
  localparam int PERIOD_W      = 13;
  localparam int MIX_W         = 3;
  localparam int NOTES_PER_OCT = 12;
  localparam int MAX_OCTAVE    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_LOAD   = 2'd2
  } state_e;

  // Octave-0 half-periods in clocks, equal-tempered from C = 5968.
  // Higher octaves are derived by right-shifting, so only one octave is stored.
  function automatic logic [PERIOD_W-1:0] base_period(input logic [NOTE_W-1:0] note);
    case (note)
      4'd0:    base_period = 13'd5968;
      4'd1:    base_period = 13'd5633;
      4'd2:    base_period = 13'd5317;
      4'd3:    base_period = 13'd5018;
      4'd4:    base_period = 13'd4737;
      4'd5:    base_period = 13'd4471;
      4'd6:    base_period = 13'd4220;
      4'd7:    base_period = 13'd3983;
      4'd8:    base_period = 13'd3760;
      4'd9:    base_period = 13'd3549;
      4'd10:   base_period = 13'd3349;
      4'd11:   base_period = 13'd3161;
      default: base_period = 13'd0;
    endcase
  endfunction

endpackage

// File: rtl/freq_gen.sv
// rtl/freq_gen.sv - note code to half-period lookup with one registered stage
//
// Purpose: maps a 7-bit note code {octave, note} to a 13-bit half-period.
// Notes 12-15 and octaves 5-7 map to 0 (silent).
// Ports:
//   clk      in   system clock
//   code_i   in   note code {octave[2:0], note[3:0]}
//   period_o out  registered half-period, valid one cycle after code_i

module freq_gen
  import voice_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic [CODE_W-1:0]   code_i,
  output logic [PERIOD_W-1:0] period_o
);

  logic [OCT_W-1:0]    octave;
  logic [NOTE_W-1:0]   note;
  logic [PERIOD_W-1:0] period_d;
  logic [PERIOD_W-1:0] period_q;

  assign octave = code_i[CODE_W-1 -: OCT_W];
  assign note   = code_i[NOTE_W-1:0];

  always_comb begin
    period_d = '0;
    if ((note < NOTE_W'(NOTES_PER_OCT)) && (octave <= OCT_W'(MAX_OCTAVE))) begin
      period_d = base_period(note) >> octave;
    end
  end

  // Table output carries no reset: it is only consumed in LOAD, which always
  // follows a LOOKUP cycle that refreshed it.
  always_ff @(posedge clk) begin
    period_q <= period_d;
  end

  assign period_o = period_q;

endmodule

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - four-voice square-wave tone scheduler with shared note lookup
//
// Purpose: accepts note on/off requests, looks up the half-period through a
// single shared freq_gen, and runs one square-wave divider per voice.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   req_valid     in   note update request
//   req_ready     out  request can be accepted this cycle
//   req_voice     in   target voice 0-3
//   req_on        in   1 = note on with req_code, 0 = note off
//   req_code      in   note code {octave, note}
//   voice_sq      out  square wave per voice
//   voice_active  out  voice has a nonzero half-period loaded
//   mix           out  registered popcount of voice_sq (one-cycle lag)

module voice_scheduler
  import voice_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [VOICE_W-1:0]    req_voice,
  input  logic                  req_on,
  input  logic [CODE_W-1:0]     req_code,
  output logic [NUM_VOICES-1:0] voice_sq,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [MIX_W-1:0]      mix
);

  state_e state_q, state_d;

  logic [VOICE_W-1:0]    voice_q, voice_d;
  logic [CODE_W-1:0]     code_q, code_d;
  logic                  load_en;
  logic                  off_en;
  logic [PERIOD_W-1:0]   lut_period;

  logic [PERIOD_W-1:0]   period_q [NUM_VOICES];
  logic [PERIOD_W-1:0]   period_d [NUM_VOICES];
  logic [PERIOD_W-1:0]   cnt_q    [NUM_VOICES];
  logic [PERIOD_W-1:0]   cnt_d    [NUM_VOICES];
  logic [NUM_VOICES-1:0] sq_q, sq_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [MIX_W-1:0]      mix_q, mix_d;

  // The captured code feeds the lookup continuously; its registered output is
  // only sampled in LOAD.
  freq_gen u_freq_gen (
    .clk      (clk),
    .code_i   (code_q),
    .period_o (lut_period)
  );

  always_comb begin
    state_d   = state_q;
    voice_d   = voice_q;
    code_d    = code_q;
    req_ready = 1'b0;
    load_en   = 1'b0;
    off_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          voice_d = req_voice;
          code_d  = req_code;
          if (req_on) begin
            state_d = ST_LOOKUP;
          end else begin
            off_en = 1'b1;
          end
        end
      end
      ST_LOOKUP: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_en = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Per-voice divider. A LOAD or note-off for a voice overrides its counter
  // step that cycle; a reload keeps the current output level so a pitch change
  // does not glitch the phase.
  always_comb begin
    sq_d     = sq_q;
    active_d = '0;
    mix_d    = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      period_d[i] = period_q[i];
      cnt_d[i]    = cnt_q[i];
      if (load_en && (voice_q == VOICE_W'(i))) begin
        period_d[i] = lut_period;
        if (lut_period != '0) begin
          cnt_d[i] = lut_period - PERIOD_W'(1);
        end else begin
          cnt_d[i] = '0;
          sq_d[i]  = 1'b0;
        end
      end else if (off_en && (req_voice == VOICE_W'(i))) begin
        period_d[i] = '0;
        cnt_d[i]    = '0;
        sq_d[i]     = 1'b0;
      end else if (period_q[i] != '0) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - PERIOD_W'(1);
        end else begin
          sq_d[i]  = ~sq_q[i];
          cnt_d[i] = period_q[i] - PERIOD_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end
      // Derived from the next period so voice_active moves on the same edge
      // as the period write.
      active_d[i] = (period_d[i] != '0);
      mix_d       = mix_d + MIX_W'(sq_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      voice_q  <= '0;
      code_q   <= '0;
      sq_q     <= '0;
      active_q <= '0;
      mix_q    <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      voice_q  <= voice_d;
      code_q   <= code_d;
      sq_q     <= sq_d;
      active_q <= active_d;
      mix_q    <= mix_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign voice_sq     = sq_q;
  assign voice_active = active_q;
  assign mix          = mix_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - self-checking bench for voice_scheduler

module tb_voice_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_on = 1'b0;
  logic [1:0] req_voice = 2'd0;
  logic [6:0] req_code = 7'd0;
  logic       req_ready;
  logic [3:0] voice_sq;
  logic [3:0] voice_active;
  logic [2:0] mix;

  voice_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_voice    (req_voice),
    .req_on       (req_on),
    .req_code     (req_code),
    .voice_sq     (voice_sq),
    .voice_active (voice_active),
    .mix          (mix)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n = 0;

  // Reference state: per voice half-period, edge at which it was loaded and
  // the output level right after that edge.
  int         per_m [4];
  int         tld_m [4];
  bit         lvl_m [4];
  bit         ready_m = 1'b1;
  bit         pend = 1'b0;
  bit         last_acc = 1'b0;
  int         pend_edge = 0;
  int         pend_voice = 0;
  logic [6:0] pend_code = 7'd0;

  function automatic int ref_period(input logic [6:0] code);
    int  oct;
    int  note;
    real base;
    oct  = int'(code[6:4]);
    note = int'(code[3:0]);
    if (note > 11 || oct > 4) return 0;
    base = 5968.0 * (2.0 ** (-(real'(note)) / 12.0));
    return $rtoi(base + 0.5) >> oct;
  endfunction

  function automatic bit lvl_at(input int v, input int m);
    if (per_m[v] == 0) return 1'b0;
    return lvl_m[v] ^ ((((m - tld_m[v]) / per_m[v]) % 2) == 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, n);
    end
  endtask

  task automatic tick();
    bit         acc;
    bit         on;
    bit         r;
    int         v;
    int         val;
    int         mix_exp;
    logic [6:0] c;
    bit   [3:0] prev;
    bit   [3:0] sq_exp;
    bit   [3:0] act_exp;
    r   = rst;
    acc = req_valid && ready_m && !r;
    on  = req_on;
    v   = int'(req_voice);
    c   = req_code;
    for (int i = 0; i < 4; i++) prev[i] = lvl_at(i, n);
    @(posedge clk);
    n++;
    #1;
    last_acc = acc;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        per_m[i] = 0;
        tld_m[i] = 0;
        lvl_m[i] = 1'b0;
      end
      pend    = 1'b0;
      ready_m = 1'b1;
      mix_exp = 0;
    end else begin
      mix_exp = int'(prev[0]) + int'(prev[1]) + int'(prev[2]) + int'(prev[3]);
      if (pend && n == pend_edge) begin
        val = ref_period(pend_code);
        per_m[pend_voice] = val;
        tld_m[pend_voice] = n;
        lvl_m[pend_voice] = (val == 0) ? 1'b0 : prev[pend_voice];
        pend    = 1'b0;
        ready_m = 1'b1;
      end
      if (acc) begin
        if (on) begin
          pend       = 1'b1;
          pend_edge  = n + 2;
          pend_voice = v;
          pend_code  = c;
          ready_m    = 1'b0;
        end else begin
          per_m[v] = 0;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      sq_exp[i]  = lvl_at(i, n);
      act_exp[i] = (per_m[i] != 0);
    end
    chk("req_ready", req_ready, ready_m);
    chk("voice_sq", voice_sq, sq_exp);
    chk("voice_active", voice_active, act_exp);
    chk("mix", mix, mix_exp);
  endtask

  task automatic send(input int v, input bit on, input logic [6:0] code);
    req_valid = 1'b1;
    req_voice = 2'(v);
    req_on    = on;
    req_code  = code;
  endtask

  task automatic wait_until(input int m);
    while (n < m) tick();
  endtask

  initial begin
    int a;
    int b;
    int guard;
    for (int i = 0; i < 4; i++) begin
      per_m[i] = 0;
      tld_m[i] = 0;
      lvl_m[i] = 1'b0;
    end

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_active", voice_active, 0);
    chk("rst_sq", voice_sq, 0);
    chk("rst_mix", mix, 0);

    // Voice 0, code 0x29: period 887, first toggle at cycle 890.
    send(0, 1'b1, 7'h29);
    tick();
    a = n;
    req_valid = 1'b0;
    chk("lookup_ready", req_ready, 0);
    tick();
    chk("load_ready", req_ready, 0);
    chk("load_active0", voice_active[0], 0);
    tick();
    chk("active0", voice_active[0], 1);
    chk("ready_back", req_ready, 1);
    wait_until(a + 888);
    chk("sq0_before", voice_sq[0], 0);
    tick();
    chk("sq0_first", voice_sq[0], 1);

    // Voice 3 loaded two periods later so it runs in phase with voice 0; a
    // held request for voice 1 (silent code) waits out LOOKUP/LOAD.
    wait_until(a + 2 * 887 - 1);
    send(3, 1'b1, 7'h29);
    tick();
    send(1, 1'b1, 7'h0C);
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!last_acc && guard < 8);
    if (!last_acc) begin
      tests++;
      fails++;
      $error("FAIL hold_timeout: held request not accepted within %0d cycles", guard);
    end
    req_valid = 1'b0;
    wait_until(a + 1790);
    chk("v1_active", voice_active[1], 0);
    chk("v1_sq", voice_sq[1], 0);
    wait_until(a + 2663);
    chk("phase_sq", {voice_sq[3], voice_sq[0]}, 2'b11);
    chk("mix_lag0", mix, 0);
    tick();
    chk("mix_two", mix, 2);
    wait_until(a + 3550);
    chk("phase_low", {voice_sq[3], voice_sq[0]}, 2'b00);
    chk("mix_lag2", mix, 2);
    tick();
    chk("mix_zero", mix, 0);
    chk("v1_still_off", voice_active[1], 0);

    // Voice 2, code 0x30 (period 746), then note-off.
    send(2, 1'b1, 7'h30);
    tick();
    b = n;
    req_valid = 1'b0;
    wait_until(b + 2 + 745);
    chk("sq2_before", voice_sq[2], 0);
    tick();
    chk("sq2_first", voice_sq[2], 1);
    wait_until(b + 1000);
    send(2, 1'b0, 7'h00);
    tick();
    req_valid = 1'b0;
    chk("off_sq2", voice_sq[2], 0);
    chk("off_active2", voice_active[2], 0);
    chk("off_ready", req_ready, 1);
    tick();
    chk("off_ready_next", req_ready, 1);

    // Reset during LOOKUP aborts the load.
    send(1, 1'b1, 7'h29);
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_sq", voice_sq, 0);
    chk("abort_active", voice_active, 0);
    chk("abort_mix", mix, 0);
    chk("abort_ready", req_ready, 1);
    repeat (3) tick();
    chk("abort_active_later", voice_active, 0);

    // Randomized traffic; requester holds each request until accepted.
    for (int k = 0; k < 4000; k++) begin
      if (!req_valid && $urandom_range(0, 5) == 0) begin
        req_valid = 1'b1;
        req_voice = 2'($urandom_range(0, 3));
        req_on    = ($urandom_range(0, 3) != 0);
        req_code  = 7'($urandom_range(0, 127));
      end
      rst = ($urandom_range(0, 1499) == 0);
      tick();
      if (last_acc) req_valid = 1'b0;
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 NUM_VOICES, default 4: number of tone voices; fixed at 4 in this revision.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  note update request.
REQ-006 req_ready  out  1  block can accept a request this cycle.
REQ-007 req_voice  in  2  target voice index 0-3.
REQ-008 req_on  in  1  1 = note on with req_code; 0 = note off.
REQ-009 req_code  in  7  note code {octave[2:0], note[3:0]}; note 0-11 = C..H.
REQ-010 voice_sq  out  4  square-wave output per voice.
REQ-011 voice_active  out  4  voice has a nonzero half-period loaded.
REQ-012 mix  out  3  registered count of voice_sq bits currently high (0-4).

Function
REQ-013 A request SHALL be accepted on the cycle where req_valid and req_ready are both 1; req_voice, req_on and req_code are captured then.
REQ-014 The FSM SHALL have exactly three states: IDLE, LOOKUP and LOAD.
REQ-015 IDLE: req_ready=1; on acceptance with req_on=1 go to LOOKUP; with req_on=0 clear period[voice], cnt[voice] and voice_sq[voice] at that edge, and stay in IDLE.
REQ-016 LOOKUP (1 cycle): req_ready=0; drive the captured code to the lookup sub-module, which registers the table value at the end of the cycle; then go to LOAD.
REQ-017 LOAD (1 cycle): req_ready=0; write the lookup value to period[voice]; if it is nonzero, load cnt[voice] with value-1; then go to IDLE.
REQ-018 In LOAD, voice_sq[voice] SHALL keep its current level, with no forced phase reset, unless the value is 0.
REQ-019 A lookup value of 0 (note 12-15, octave 5-7) SHALL silence the voice: period=0, cnt=0, voice_sq=0, voice_active=0.
REQ-020 Note-on acceptance-to-LOAD latency SHALL be 2 cycles; req_ready SHALL return high on the cycle after LOAD.
REQ-021 Voice counter behaviour when period≠0:
  - if cnt≠0: decrement cnt;
  - if cnt=0: toggle voice_sq and reload cnt=period-1;
  - result: half-period = period clocks.
REQ-022 Voice counter behaviour when period=0: cnt and voice_sq SHALL be held at 0.
REQ-023 A LOAD write SHALL take priority over that voice's counter update in the same cycle; other voices keep running.
REQ-024 voice_active[i] SHALL be (period[i]≠0), registered.
REQ-025 mix SHALL be the popcount of voice_sq, registered, so it lags voice_sq by one cycle.
REQ-026 period SHALL be 13 bits unsigned; decrement SHALL never wrap below 0.
REQ-027 Requests presented while req_ready=0 SHALL be ignored; the requester holds them.

Reset
REQ-028 On rst, the block SHALL:
  - set FSM=IDLE, req_ready=1;
  - clear all period, cnt, voice_sq, voice_active and mix;
  - abort any in-flight LOOKUP/LOAD with no write.
REQ-029 The lookup table contents are unaffected by reset; its output SHALL be consumed only in LOAD.

Structure
REQ-030 A shared package SHALL hold:
  - the FSM state encoding;
  - NUM_VOICES;
  - code field widths (octave 3, note 4);
  - period width 13.
REQ-031 The block SHALL instantiate exactly one sub-module, freq_gen (7-bit note code in, registered 13-bit period out, 1-cycle latency), as the sole shared lookup resource.

Verification
REQ-032 Reset, then accept {voice 0, on, 0x29} at cycle 0 -> LOAD at cycle 2, period[0]=887, voice_active[0]=1 at cycle 3, first voice_sq[0] toggle visible at cycle 890, then every 887 cycles.
REQ-033 Note-on 0x0C to voice 1 -> period 0, voice_sq[1]=0 and voice_active[1]=0 permanently.
REQ-034 Voice 2 running with code 0x30 (period 746), then note-off -> voice_sq[2]=0 and voice_active[2]=0 on the next cycle; req_ready never drops.
REQ-035 Hold req_valid with a new request during LOOKUP/LOAD -> no capture until req_ready=1, then the held request is accepted exactly once.
REQ-036 Voices 0 and 3 both running with code 0x29, in phase -> mix=2 while both are high, 0 while both are low, with one-cycle lag.
REQ-037 Assert rst in the LOOKUP cycle -> no period write, all outputs 0, req_ready=1 after reset.
